sdp_y_core_chn_in_fifo_rsci: RTL and testbench
==============================================

Name: sdp_y_core_chn_in_fifo_rsci

Overview:
- Parametrised successor to the single-slot SDP Y-core input-channel interface.
- Sits between an upstream valid/load channel (z/vz/lz) and the Y-core datapath (ALU/MUL/LUT operand channels).
- Holds up to DEPTH words while the core stalls, instead of a single skid slot.
- Adds an optional empty-bypass mode, a synchronous flush and an occupancy output.

Parameters:
- WIDTH, 128: data width of each channel word.
- DEPTH, 4: buffer entries; legal range 2..16; need not be a power of two.
- BYPASS, 1: 1 = when empty, upstream data is visible to the core in the same cycle; 0 = registered only (one-cycle minimum latency).

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on the rising edge.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- chn_rsc_z  in  WIDTH  upstream data.
- chn_rsc_vz  in  1  upstream valid.
- chn_rsc_lz  out  1  load/ready to upstream.
- chn_rsci_oswt  in  1  core requests a word this cycle.
- core_wen  in  1  core advances this cycle.
- chn_rsci_flush  in  1  synchronous discard of all buffered words.
- chn_rsci_bawt  out  1  a word is available to the core.
- chn_rsci_wen_comp  out  1  core may proceed; equals ~oswt | bawt.
- chn_rsci_d_mxwt  out  WIDTH  word presented to the core.
- chn_rsci_cnt  out  CW  occupancy, where CW = clog2(DEPTH+1).

Behaviour:
- Reset (asynchronous, rstn=0):
  - Occupancy, read pointer and write pointer = 0.
  - Storage array is not reset.
  - Outputs while in reset and after release: lz=1, cnt=0, bawt=(BYPASS ? vz : 0), d_mxwt=(BYPASS ? z : 0).
- Definitions:
  - full = (cnt==DEPTH); empty = (cnt==0).
  - push = vz & lz.
  - pop = oswt & core_wen & bawt.
- lz = ~full & ~flush. It is registered-state only and has no combinational path from oswt or core_wen.
- Head word:
  - empty & BYPASS=1: bawt=vz, d_mxwt=z.
  - empty & BYPASS=0: bawt=0, d_mxwt forced to 0.
  - otherwise: bawt=1, d_mxwt=mem[rd_ptr].
- Per-cycle update (flush has priority):
  - flush: cnt, rd_ptr, wr_ptr <= 0. Any push or pop in that cycle is ignored; lz=0 that cycle.
  - empty, BYPASS=1, push & pop: word passes straight through. Nothing is stored and cnt stays 0.
  - push only: mem[wr_ptr] <= z; wr_ptr advances; cnt+1.
  - pop only: rd_ptr advances; cnt-1.
  - push & pop, not empty: write and read both occur; cnt unchanged.
- Pointers wrap from DEPTH-1 to 0 using an explicit compare, with no modulo-2^n assumption.
- Full: lz=0, so vz is held upstream. A pop while full frees a slot; lz rises the next cycle, not the same cycle.
- Latency:
  - BYPASS=1, empty: 0 cycles z to d_mxwt.
  - Otherwise: 1 cycle after the push edge.
- Ordering: strict FIFO; no word is lost or duplicated except by flush.
- oswt=1 with core_wen=0: no pop; head word is held stable.
- cnt never exceeds DEPTH and never underflows. Verification asserts this, plus: bawt=0 implies no pop, and lz=0 implies no push.
- Reset mid-operation: all buffered words are discarded and pointers return to 0. The first post-reset push lands in mem[0].

Decomposition:
- Shared package sdp_y_core_rsci_pkg:
  - function cnt_width(depth) returning clog2(depth+1).
  - function ptr_inc(ptr, depth) implementing the explicit wrap.
  - localparam defaults for WIDTH, DEPTH and BYPASS.
- One sub-module, sdp_y_core_rsci_fifo_mem: DEPTH x WIDTH register array with one write port and one asynchronous read port, no reset.
- The top level holds pointers, occupancy, the bypass mux and the handshake logic.

Test Plan:
- Reset then idle, BYPASS=1, vz=1, z=0xA5: bawt=1, d_mxwt=0xA5 combinationally; with oswt=core_wen=1, cnt stays 0 and lz=1.
- BYPASS=0, DEPTH=4: push 0x1,0x2,0x3,0x4 with oswt=0 → cnt=4 and lz=0. A fifth vz is held. Then pop 4 cycles → d_mxwt reads 1,2,3,4; cnt=0; bawt=0 and d_mxwt=0.
- DEPTH=3: continuous push+pop for 10 words 0..9 with a one-deep preload → pointers wrap 2→0 and output order is 0..9. cnt holds at 1.
- Full, then oswt=1 with core_wen=0 for 3 cycles: head word unchanged and cnt=DEPTH. Raise core_wen for 1 cycle → cnt=DEPTH-1, and lz=1 the following cycle.
- cnt=3, flush=1 together with vz=1 and a pop request: next cycle cnt=0 and bawt=0 (BYPASS=0); lz=0 during the flush cycle; the pushed word is absent.
- Assert rstn=0 asynchronously mid-stream with cnt=2: outputs take reset values immediately. After release, push 0x7 → it is read back as the first word.

Source files
------------

// File: rtl/sdp_y_core_rsci_pkg.sv
// Shared helpers and defaults for the SDP Y-core input-channel FIFO interface.
package sdp_y_core_rsci_pkg;

  localparam int unsigned DEF_WIDTH  = 128;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam bit          DEF_BYPASS = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sdp_y_core_rsci_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module sdp_y_core_rsci_fifo_mem #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sdp_y_core_chn_in_fifo_rsci.sv
// SDP Y-core input-channel interface: DEPTH-entry FIFO between the upstream
// valid/load channel and the core, with optional empty-bypass and flush.
module sdp_y_core_chn_in_fifo_rsci
  import sdp_y_core_rsci_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter bit          BYPASS = DEF_BYPASS
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  input  logic [WIDTH-1:0]              chn_rsc_z,
  input  logic                          chn_rsc_vz,
  output logic                          chn_rsc_lz,
  input  logic                          chn_rsci_oswt,
  input  logic                          core_wen,
  input  logic                          chn_rsci_flush,
  output logic                          chn_rsci_bawt,
  output logic                          chn_rsci_wen_comp,
  output logic [WIDTH-1:0]              chn_rsci_d_mxwt,
  output logic [cnt_width(DEPTH)-1:0]   chn_rsci_cnt
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             pass_thru;
  logic             mem_we;
  logic             rd_adv;

  always_comb begin
    full  = (cnt == CW'(DEPTH));
    empty = (cnt == '0);

    chn_rsc_lz = ~full & ~chn_rsci_flush;

    if (empty) begin
      chn_rsci_bawt   = BYPASS ? chn_rsc_vz : 1'b0;
      chn_rsci_d_mxwt = BYPASS ? chn_rsc_z  : '0;
    end else begin
      chn_rsci_bawt   = 1'b1;
      chn_rsci_d_mxwt = rd_data;
    end

    push = chn_rsc_vz & chn_rsc_lz;
    pop  = chn_rsci_oswt & core_wen & chn_rsci_bawt;

    // An empty bypassed word consumed in the same cycle never touches storage.
    pass_thru = BYPASS && empty && push && pop;
    mem_we    = push & ~pass_thru;
    rd_adv    = pop & ~pass_thru;

    chn_rsci_wen_comp = ~chn_rsci_oswt | chn_rsci_bawt;
    chn_rsci_cnt      = cnt;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (chn_rsci_flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
      end
      if (rd_adv) begin
        rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
      end
      case ({mem_we, rd_adv})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  sdp_y_core_rsci_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .nvdla_core_clk (nvdla_core_clk),
    .wr_en          (mem_we),
    .wr_addr        (wr_ptr),
    .wr_data        (chn_rsc_z),
    .rd_addr        (rd_ptr),
    .rd_data        (rd_data)
  );

endmodule

// File: tb/tb_sdp_y_core_chn_in_fifo_rsci.sv
// Bench: two instances (BYPASS=0/DEPTH=4 and BYPASS=1/DEPTH=3) share one stimulus,
// checked every cycle against a queue model plus directed literal expectations.
module tb_sdp_y_core_chn_in_fifo_rsci;

  localparam int W = 16;
  localparam int DEP [2] = '{4, 3};
  localparam bit BYP [2] = '{1'b0, 1'b1};

  logic         clk;
  logic         rstn;
  logic [W-1:0] z;
  logic         vz;
  logic         oswt;
  logic         wen;
  logic         flush;

  logic         lz      [2];
  logic         bawt    [2];
  logic         wcomp   [2];
  logic [W-1:0] dm      [2];
  logic [2:0]   cnt0;
  logic [1:0]   cnt1;

  int n_cmp  = 0;
  int n_fail = 0;

  sdp_y_core_chn_in_fifo_rsci #(.WIDTH(W), .DEPTH(4), .BYPASS(1'b0)) u_dut0 (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .chn_rsc_z         (z),
    .chn_rsc_vz        (vz),
    .chn_rsc_lz        (lz[0]),
    .chn_rsci_oswt     (oswt),
    .core_wen          (wen),
    .chn_rsci_flush    (flush),
    .chn_rsci_bawt     (bawt[0]),
    .chn_rsci_wen_comp (wcomp[0]),
    .chn_rsci_d_mxwt   (dm[0]),
    .chn_rsci_cnt      (cnt0)
  );

  sdp_y_core_chn_in_fifo_rsci #(.WIDTH(W), .DEPTH(3), .BYPASS(1'b1)) u_dut1 (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .chn_rsc_z         (z),
    .chn_rsc_vz        (vz),
    .chn_rsc_lz        (lz[1]),
    .chn_rsci_oswt     (oswt),
    .core_wen          (wen),
    .chn_rsci_flush    (flush),
    .chn_rsci_bawt     (bawt[1]),
    .chn_rsci_wen_comp (wcomp[1]),
    .chn_rsci_d_mxwt   (dm[1]),
    .chn_rsci_cnt      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue of buffered words per instance.
  logic [W-1:0] mq [2][$];

  int           m_sz;
  logic [W-1:0] m_head;
  bit           m_lz;
  bit           m_bawt;
  logic [W-1:0] m_d;
  bit           m_push;
  bit           m_pop;

  always @(posedge clk or negedge rstn) begin
    if (!rstn || flush) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sz   = mq[i].size();
        m_lz   = (m_sz < DEP[i]);
        m_bawt = (m_sz == 0) ? (BYP[i] && vz) : 1'b1;
        m_push = vz && m_lz;
        m_pop  = oswt && wen && m_bawt;
        if (m_sz != 0 && m_pop) void'(mq[i].pop_front());
        if (m_push && !(m_sz == 0 && m_pop)) mq[i].push_back(z);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_sz   = mq[i].size();
      m_head = (m_sz > 0) ? mq[i][0] : '0;
      m_lz   = (m_sz < DEP[i]) && !flush;
      m_bawt = (m_sz == 0) ? (BYP[i] && vz) : 1'b1;
      m_d    = (m_sz == 0) ? (BYP[i] ? z : '0) : m_head;
      chk($sformatf("lz[%0d]", i),    64'(lz[i]),    64'(m_lz));
      chk($sformatf("bawt[%0d]", i),  64'(bawt[i]),  64'(m_bawt));
      chk($sformatf("wcomp[%0d]", i), 64'(wcomp[i]), 64'(!oswt || m_bawt));
      chk($sformatf("d_mxwt[%0d]", i), 64'(dm[i]),   64'(m_d));
      chk($sformatf("cnt[%0d]", i),   (i == 0) ? 64'(cnt0) : 64'(cnt1), 64'(m_sz));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; z = 16'hA5; vz = 1'b1; oswt = 1'b0; wen = 1'b0; flush = 1'b0;

    // Reset values, bypass visible on instance 1.
    #3;
    chk("rst_lz0", 64'(lz[0]), 64'd1);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_bawt0", 64'(bawt[0]), 64'd0);
    chk("rst_d0", 64'(dm[0]), 64'd0);
    chk("rst_bawt1", 64'(bawt[1]), 64'd1);
    chk("rst_d1", 64'(dm[1]), 64'hA5);
    #4;
    rstn = 1'b1; oswt = 1'b1; wen = 1'b1;
    #1;
    chk("byp_bawt1", 64'(bawt[1]), 64'd1);
    chk("byp_d1", 64'(dm[1]), 64'hA5);
    chk("byp_lz1", 64'(lz[1]), 64'd1);
    cyc();
    chk("byp_cnt1", 64'(cnt1), 64'd0);
    vz = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;

    // Fill instance 0, hold a fifth word, stall the core, then drain.
    vz = 1'b1; oswt = 1'b0; wen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      z = W'(k);
      cyc();
    end
    chk("full_cnt0", 64'(cnt0), 64'd4);
    chk("full_lz0", 64'(lz[0]), 64'd0);
    z = 16'h5;
    cyc();
    chk("held_cnt0", 64'(cnt0), 64'd4);
    oswt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_d0", 64'(dm[0]), 64'd1);
      chk("stall_cnt0", 64'(cnt0), 64'd4);
    end
    vz = 1'b0; wen = 1'b1;
    #1;
    chk("popfull_lz0", 64'(lz[0]), 64'd0);
    cyc();
    chk("pop1_cnt0", 64'(cnt0), 64'd3);
    chk("pop1_lz0", 64'(lz[0]), 64'd1);
    for (int k = 2; k <= 4; k++) begin
      chk("drain_d0", 64'(dm[0]), 64'(k));
      cyc();
    end
    chk("empty_cnt0", 64'(cnt0), 64'd0);
    chk("empty_bawt0", 64'(bawt[0]), 64'd0);
    chk("empty_d0", 64'(dm[0]), 64'd0);

    // Streaming through depth 3 with one word preloaded: pointers wrap.
    vz = 1'b1; oswt = 1'b0; wen = 1'b0; z = 16'h0;
    cyc();
    oswt = 1'b1; wen = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      z = W'(k);
      #1;
      chk("wrap_d1", 64'(dm[1]), 64'(k - 1));
      chk("wrap_cnt1", 64'(cnt1), 64'd1);
      cyc();
    end
    vz = 1'b0;
    #1;
    chk("wrap_last_d1", 64'(dm[1]), 64'd9);
    cyc();
    chk("wrap_end_cnt1", 64'(cnt1), 64'd0);

    // Flush with three buffered words, a concurrent push and pop request.
    vz = 1'b1; oswt = 1'b0; wen = 1'b0;
    z = 16'h11; cyc();
    z = 16'h22; cyc();
    z = 16'h33; cyc();
    chk("preflush_cnt0", 64'(cnt0), 64'd3);
    flush = 1'b1; z = 16'h44; oswt = 1'b1; wen = 1'b1;
    #1;
    chk("flush_lz0", 64'(lz[0]), 64'd0);
    chk("flush_lz1", 64'(lz[1]), 64'd0);
    cyc();
    flush = 1'b0; vz = 1'b0; oswt = 1'b0; wen = 1'b0;
    #1;
    chk("postflush_cnt0", 64'(cnt0), 64'd0);
    chk("postflush_bawt0", 64'(bawt[0]), 64'd0);
    vz = 1'b1; z = 16'h55;
    cyc();
    vz = 1'b0;
    #1;
    chk("postflush_d0", 64'(dm[0]), 64'h55);
    chk("postflush_cnt0b", 64'(cnt0), 64'd1);

    // Asynchronous reset mid-stream with two words buffered.
    vz = 1'b1; z = 16'h66;
    cyc();
    vz = 1'b0;
    #1;
    chk("prerst_cnt0", 64'(cnt0), 64'd2);
    rstn = 1'b0;
    #1;
    chk("arst_cnt0", 64'(cnt0), 64'd0);
    chk("arst_lz0", 64'(lz[0]), 64'd1);
    chk("arst_bawt0", 64'(bawt[0]), 64'd0);
    chk("arst_d0", 64'(dm[0]), 64'd0);
    chk("arst_cnt1", 64'(cnt1), 64'd0);
    cyc();
    rstn = 1'b1; vz = 1'b1; z = 16'h7;
    cyc();
    vz = 1'b0; z = 16'h0;
    #1;
    chk("post_rst_d0", 64'(dm[0]), 64'h7);
    chk("post_rst_d1", 64'(dm[1]), 64'h7);
    chk("post_rst_cnt0", 64'(cnt0), 64'd1);
    oswt = 1'b1; wen = 1'b1;
    cyc();
    chk("post_rst_pop_cnt0", 64'(cnt0), 64'd0);
    oswt = 1'b0; wen = 1'b0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
